// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the bit serializer: FSM encoding and default word width.
package seq_ser_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC  = 2'd1;
  localparam logic [1:0] ST_PARITY_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE_ENC,
    SHIFT  = ST_SHIFT_ENC,
    PARITY = ST_PARITY_ENC
  } state_t;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-word valid/ready handshake feeding the serializer.
interface seq_bit_serializer_if
  import seq_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_bit_serializer_shift_reg.sv
// Load/shift register whose edge bit is the serial output; with SER_PARITY_EN it also
// captures the word parity at load.
module ser_shift_reg
  import seq_ser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
`ifdef SER_PARITY_EN
  , output logic           par_o
`endif
);
  logic [WIDTH-1:0] sr_q, sr_d;

  // Load wins over shift so a back-to-back word replaces the drained register.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], fill_i} : {fill_i, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr_q <= '0;
    else      sr_q <= sr_d;
  end

  assign bit_o = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

`ifdef SER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        par_q <= 1'b0;
    else if (load_i) par_q <= ^data_i;
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the 1010 detector. Define SER_PARITY_EN to append an
// even-parity bit after every word.
module seq_bit_serializer
  import seq_ser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_bit_serializer_if.slave  in_if,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 busy
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_valid_q, busy_q;
  logic             in_ready, accept, last, load, shift, fill, sr_bit;

  assign last = (cnt_q == CNT_LAST);

`ifdef SER_PARITY_EN
  logic sr_par;
  // Parity enters the vacated end on the first shift and surfaces right after the last data bit.
  assign fill     = (cnt_q == '0) && sr_par;
  assign in_ready = rst && (state_q == IDLE || state_q == PARITY);
`else
  assign fill     = 1'b0;
  assign in_ready = rst && (state_q == IDLE || (state_q == SHIFT && last));
`endif

  assign accept         = in_if.in_valid && in_ready;
  assign in_if.in_ready = in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: load = accept;
      SHIFT: begin
        shift = 1'b1;
        if (!last) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
`ifdef SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
          load    = accept;
`endif
        end
      end
      PARITY: begin
        shift   = 1'b1;
        state_d = IDLE;
        load    = accept;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ser_valid_q <= (state_d != IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .fill_i  (fill),
    .data_i  (in_if.in_data),
    .bit_o   (sr_bit)
`ifdef SER_PARITY_EN
    , .par_o (sr_par)
`endif
  );

  assign ser_out   = sr_bit;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances at WIDTH=4.
`timescale 1ns/1ps
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_bit_serializer_if #(.WIDTH(4)) m_if ();
  seq_bit_serializer_if #(.WIDTH(4)) l_if ();

  logic m_out, m_vld, m_busy;
  logic l_out, l_vld, l_busy;

  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .in_if(m_if.slave),
    .ser_out(m_out), .ser_valid(m_vld), .busy(m_busy)
  );

  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .in_if(l_if.slave),
    .ser_out(l_out), .ser_valid(l_vld), .busy(l_busy)
  );

`ifdef SER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  task automatic test_reset();
    rst = 1'b0;
    m_if.in_valid = 1'b0; m_if.in_data = '0;
    l_if.in_valid = 1'b0; l_if.in_data = '0;
    #1;
    n_chk++; if (m_out !== 1'b0) begin n_fail++; $display("FAIL reset_ser_out: got %b want 0", m_out); end
    n_chk++; if (m_vld !== 1'b0) begin n_fail++; $display("FAIL reset_ser_valid: got %b want 0", m_vld); end
    n_chk++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    n_chk++; if (m_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_m: got %b want 0", m_if.in_ready); end
    n_chk++; if (l_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_l: got %b want 0", l_if.in_ready); end
    #9 rst = 1'b1;
    #1;
    n_chk++; if (m_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", m_if.in_ready); end
    @(posedge clk); #1;
    n_chk++; if (m_vld !== 1'b0 || m_out !== 1'b0 || m_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_release: got vld=%b out=%b busy=%b want 0 0 0", m_vld, m_out, m_busy); end
  endtask

  task automatic test_single_word();
    logic [4:0] exp = 5'b00101;
    @(negedge clk);
    m_if.in_data = 4'b1010; m_if.in_valid = 1'b1;
    n_chk++; if (m_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_idle: got %b want 1", m_if.in_ready); end
    @(posedge clk); #1;
    m_if.in_valid = 1'b0; m_if.in_data = 4'b1111;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_chk++; if (m_out !== exp[i] || m_vld !== 1'b1 || m_busy !== 1'b1) begin n_fail++; $display("FAIL single_bit%0d: got out=%b vld=%b busy=%b want %b 1 1", i, m_out, m_vld, m_busy, exp[i]); end
    end
    @(posedge clk); #1;
    n_chk++; if (m_vld !== 1'b0 || m_out !== 1'b0 || m_busy !== 1'b0) begin n_fail++; $display("FAIL single_end: got vld=%b out=%b busy=%b want 0 0 0", m_vld, m_out, m_busy); end
  endtask

  task automatic test_back_to_back();
`ifdef SER_PARITY_EN
    logic [9:0] e_bit = 10'b1001011011;
    logic [9:0] e_rdy = 10'b1000010000;
`else
    logic [9:0] e_bit = 10'b0000101011;
    logic [9:0] e_rdy = 10'b0010001000;
`endif
    @(negedge clk);
    m_if.in_data = 4'b1101; m_if.in_valid = 1'b1;
    @(posedge clk); #1;
    m_if.in_data = 4'b0100;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_chk++; if (m_out !== e_bit[i] || m_vld !== 1'b1 || m_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_bit%0d: got out=%b vld=%b busy=%b want %b 1 1", i, m_out, m_vld, m_busy, e_bit[i]); end
      n_chk++; if (m_if.in_ready !== e_rdy[i]) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want %b", i, m_if.in_ready, e_rdy[i]); end
      if (i == NB) m_if.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    n_chk++; if (m_vld !== 1'b0 || m_out !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got vld=%b out=%b want 0 0", m_vld, m_out); end
  endtask

  task automatic test_lsb_first();
    logic [4:0] exp = 5'b00101;
    @(negedge clk);
    l_if.in_data = 4'b0101; l_if.in_valid = 1'b1;
    @(posedge clk); #1;
    l_if.in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_chk++; if (l_out !== exp[i] || l_vld !== 1'b1) begin n_fail++; $display("FAIL lsb_bit%0d: got out=%b vld=%b want %b 1", i, l_out, l_vld, exp[i]); end
    end
    @(posedge clk); #1;
    n_chk++; if (l_vld !== 1'b0 || l_busy !== 1'b0) begin n_fail++; $display("FAIL lsb_end: got vld=%b busy=%b want 0 0", l_vld, l_busy); end
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] exp = 5'b00110;
    @(negedge clk);
    m_if.in_data = 4'b1010; m_if.in_valid = 1'b1;
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    n_chk++; if (m_out !== 1'b1) begin n_fail++; $display("FAIL midrst_bit0: got %b want 1", m_out); end
    @(posedge clk); #1;
    n_chk++; if (m_out !== 1'b0 || m_vld !== 1'b1) begin n_fail++; $display("FAIL midrst_bit1: got out=%b vld=%b want 0 1", m_out, m_vld); end
    #2 rst = 1'b0;
    #1;
    n_chk++; if (m_vld !== 1'b0 || m_out !== 1'b0 || m_busy !== 1'b0 || m_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: got vld=%b out=%b busy=%b rdy=%b want 0 0 0 0", m_vld, m_out, m_busy, m_if.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++; if (m_vld !== 1'b0 || m_out !== 1'b0) begin n_fail++; $display("FAIL midrst_residual%0d: got vld=%b out=%b want 0 0", i, m_vld, m_out); end
    end
    @(negedge clk);
    m_if.in_data = 4'b0110; m_if.in_valid = 1'b1;
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_chk++; if (m_out !== exp[i] || m_vld !== 1'b1) begin n_fail++; $display("FAIL midrst_next_bit%0d: got out=%b vld=%b want %b 1", i, m_out, m_vld, exp[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_parity();
    logic [4:0] exp = 5'b11101;
    @(negedge clk);
    m_if.in_data = 4'b1011; m_if.in_valid = 1'b1;
    @(posedge clk); #1;
    m_if.in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_chk++; if (m_out !== exp[i] || m_vld !== 1'b1) begin n_fail++; $display("FAIL parity_bit%0d: got out=%b vld=%b want %b 1", i, m_out, m_vld, exp[i]); end
    end
    @(posedge clk); #1;
    n_chk++; if (m_vld !== 1'b0 || m_out !== 1'b0 || m_busy !== 1'b0) begin n_fail++; $display("FAIL parity_end: got vld=%b out=%b busy=%b want 0 0 0", m_vld, m_out, m_busy); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
